fixed_point_engine: RTL and testbench
=====================================

# fixed_point_engine

Sequential, parametrised fixed-point arithmetic engine for the LUMOS datapath. Performs signed Q(WIDTH−FBITS).FBITS add, subtract, multiply and square root behind a start/ready handshake. Multiply is built from four time-multiplexed half-width partial products, and square root is a bit-serial digit recurrence. Sits between the register-file read stage and writeback, and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand/result width; must be even.
- `FBITS`, 10: fractional bits; WIDTH+FBITS must be even.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset; one clock domain only.
- `start`  input  1  request strobe; sampled only when `busy`=0.
- `operation`  input  2  00 ADD, 01 SUB, 10 MUL, 11 SQRT; captured with `start`.
- `operand_1`  input  WIDTH  signed fixed-point A; captured with `start`.
- `operand_2`  input  WIDTH  signed fixed-point B; captured with `start`; ignored for SQRT.
- `result`  output  WIDTH  registered result; held until the next accepted `start`.
- `ready`  output  1  one-cycle completion pulse.
- `busy`  output  1  high from the cycle after `start` acceptance until the cycle `ready` pulses, inclusive.
- `error`  output  1  valid with `ready`: SQRT of a negative operand, or overflow when saturation is enabled.

## Operation
- Reset values: `result`=0, `ready`=0, `busy`=0, `error`=0, state=IDLE, all internal registers 0.
- States:
  - IDLE: on `start`, latch the operation and operands, then go to EXEC.
  - EXEC: runs the selected algorithm; on its final step, go to DONE.
  - DONE: pulse `ready`, write `result`/`error`, return to IDLE.
- ADD/SUB: two's-complement WIDTH+1-bit sum; result = low WIDTH bits. Overflow means bit WIDTH ≠ bit WIDTH−1.
- MUL:
  - Convert operands to magnitudes. Split each into hi/lo halves (H = WIDTH/2).
  - One H×H `half_multiplier` instance computes one partial product per cycle, in the order lo·lo, lo·hi, hi·lo, hi·hi.
  - Accumulate with shifts of 0, H, H, 2H into a 2·WIDTH accumulator.
  - Apply the sign (A xor B). result = acc[WIDTH+FBITS−1:FBITS], truncated toward −∞ after negation.
  - Overflow means bits [2·WIDTH−1:WIDTH+FBITS−1] are not all equal.
- SQRT:
  - Radicand = {operand_1, FBITS zeros}, treated as unsigned.
  - Restoring digit recurrence, one result bit per cycle, N = (WIDTH+FBITS)/2 iterations.
  - result = floor(sqrt(A)) in the same Q format, zero-extended.
  - A negative operand (MSB set) skips EXEC and goes straight to DONE with result=0 and `error`=1.
- `start` while `busy`=1 is ignored. No queueing, and no change to the in-flight operation.

## Timing
- `start` is accepted in cycle 0. `ready` is high in cycle L, and `result` is valid from cycle L onward.
- Latency L: ADD/SUB 1 (DONE entered directly), MUL 5, SQRT N+1 (22 at defaults), negative SQRT 1.
- `busy` is high in cycles 1..L. A new `start` is accepted in cycle L+1 at the earliest. `start` in cycle L is ignored.
- Reset asserted mid-operation aborts within the same instant: all outputs return to reset values, and the partial work is discarded.
- No combinational path from inputs to outputs.

## Configuration
- `FPU_SATURATE_EN` defined:
  - ADD/SUB/MUL overflow clamps `result` to 0x7FF…F (positive) or 0x800…0 (negative) and sets `error`=1 with `ready`.
- Not defined:
  - Results wrap (low bits kept) and `error` is asserted only for negative SQRT.
  - Saturation logic is absent from the netlist.

## Structure
- Shared package `fpu_pkg`: opcode constants (FPU_ADD/SUB/MUL/SQRT), the state encoding (IDLE/EXEC/DONE), and the partial-product step index constants.
- One sub-module, `half_multiplier`: a combinational H×H unsigned multiplier, parametrised by H, instantiated exactly once.
- The square root stays inline in the FSM; no separate module.

## Test plan
All scenarios at WIDTH=32, FBITS=10.
- ADD 0x00000600 + 0x00000800 (1.5+2.0) → `result`=0x00000E00, `ready` in cycle 1, `error`=0.
- MUL 0xFFFFFA00 × 0x00000800 (−1.5×2.0) → 0xFFFFF400, `ready` exactly in cycle 5, `busy` high cycles 1–5.
- SQRT 0x00000800 (2.0) → 0x000005A8, `ready` in cycle 22; SQRT 0xFFFFF000 → 0, `error`=1, `ready` in cycle 1.
- ADD 0x7FFFFFFF + 0x00000001:
  - `FPU_SATURATE_EN` defined → 0x7FFFFFFF, `error`=1.
  - Not defined → 0x80000000, `error`=0.
- SQRT 0x00001000 started, then `start`+ADD pulsed in cycle 3 → ADD ignored, SQRT returns 0x00000800, no extra `ready`.
- SQRT started, `reset` driven low in cycle 10 → `busy`/`ready`/`result` go to 0 immediately. After release, MUL 0x00000C00×0x00000400 (3.0×1.0) → 0x00000C00.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - opcodes, FSM state encoding and partial-product step indices for fixed_point_engine
package fpu_pkg;

  localparam logic [1:0] FPU_ADD  = 2'b00;
  localparam logic [1:0] FPU_SUB  = 2'b01;
  localparam logic [1:0] FPU_MUL  = 2'b10;
  localparam logic [1:0] FPU_SQRT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Partial-product order: lo*lo, lo*hi, hi*lo, hi*hi (operand A half first)
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

endpackage

// File: rtl/fixed_point_engine_half_multiplier.sv
// rtl/fixed_point_engine_half_multiplier.sv - combinational HxH unsigned multiplier shared by the MUL steps
module half_multiplier #(
  parameter int H = 16
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-1:0] p
);

  assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/fixed_point_engine.sv
// rtl/fixed_point_engine.sv - sequential Q(WIDTH-FBITS).FBITS add/sub/mul/sqrt engine behind start/ready
// Optional feature macro: FPU_SATURATE_EN (clamp ADD/SUB/MUL overflow and flag error).
module fixed_point_engine
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             error
);

  localparam int H  = WIDTH / 2;
  localparam int N  = (WIDTH + FBITS) / 2;
  localparam int IW = $clog2(N + 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic [1:0]         step_q, step_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*N-1:0]     rad_q, rad_d;
  logic [N:0]         rem_q, rem_d;
  logic [N-1:0]       root_q, root_d;
  logic [IW-1:0]      iter_q, iter_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               error_q, error_d;

  // ADD/SUB is resolved straight from the inputs so DONE follows acceptance directly
  logic [WIDTH-1:0] add_res;
  logic             add_err;

`ifdef FPU_SATURATE_EN
  logic [WIDTH:0] add_sum;

  always_comb begin
    if (operation == FPU_SUB) begin
      add_sum = {operand_1[WIDTH-1], operand_1} - {operand_2[WIDTH-1], operand_2};
    end else begin
      add_sum = {operand_1[WIDTH-1], operand_1} + {operand_2[WIDTH-1], operand_2};
    end
    add_err = add_sum[WIDTH] ^ add_sum[WIDTH-1];
    if (add_err) begin
      add_res = add_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      add_res = add_sum[WIDTH-1:0];
    end
  end
`else
  always_comb begin
    add_res = (operation == FPU_SUB) ? (operand_1 - operand_2) : (operand_1 + operand_2);
    add_err = 1'b0;
  end
`endif

  logic [H-1:0]       pp_a;
  logic [H-1:0]       pp_b;
  logic [WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0] pp_shift;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_err;

  half_multiplier #(.H(H)) u_half_mul (
    .a (pp_a),
    .b (pp_b),
    .p (pp)
  );

  always_comb begin
    pp_a = (step_q == STEP_HL || step_q == STEP_HH) ? mag_a_q[WIDTH-1:H] : mag_a_q[H-1:0];
    pp_b = (step_q == STEP_LH || step_q == STEP_HH) ? mag_b_q[WIDTH-1:H] : mag_b_q[H-1:0];
    case (step_q)
      STEP_LL: pp_shift = {{WIDTH{1'b0}}, pp};
      STEP_HH: pp_shift = {pp, {WIDTH{1'b0}}};
      default: pp_shift = {{H{1'b0}}, pp, {H{1'b0}}};
    endcase
    acc_next = acc_q + pp_shift;
    // Negating the full product before the arithmetic slice gives floor rounding
    mul_prod = neg_q ? -acc_next : acc_next;
    mul_res  = mul_prod[WIDTH+FBITS-1:FBITS];
    mul_err  = 1'b0;
`ifdef FPU_SATURATE_EN
    if (!((&mul_prod[2*WIDTH-1:WIDTH+FBITS-1]) || (~|mul_prod[2*WIDTH-1:WIDTH+FBITS-1]))) begin
      mul_err = 1'b1;
      mul_res = mul_prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  logic [N+2:0] rem_sh;
  logic [N+2:0] trial;
  logic [N+2:0] rem_diff;
  logic         take;

  always_comb begin
    rem_sh   = {rem_q, rad_q[2*N-1 -: 2]};
    trial    = {1'b0, root_q, 2'b01};
    take     = (rem_sh >= trial);
    rem_diff = rem_sh - trial;
  end

  logic unused_bits;
  assign unused_bits = ^{mul_prod[2*WIDTH-1:WIDTH+FBITS], mul_prod[FBITS-1:0], rem_diff[N+2:N+1]};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    step_d   = step_q;
    acc_d    = acc_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    iter_d   = iter_q;
    result_d = result_q;
    error_d  = error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = operation;
          case (operation)
            FPU_ADD, FPU_SUB: begin
              result_d = add_res;
              error_d  = add_err;
              state_d  = ST_DONE;
            end
            FPU_MUL: begin
              mag_a_d = operand_1[WIDTH-1] ? -operand_1 : operand_1;
              mag_b_d = operand_2[WIDTH-1] ? -operand_2 : operand_2;
              neg_d   = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
              acc_d   = '0;
              step_d  = STEP_LL;
              state_d = ST_EXEC;
            end
            default: begin
              if (operand_1[WIDTH-1]) begin
                result_d = '0;
                error_d  = 1'b1;
                state_d  = ST_DONE;
              end else begin
                rad_d   = {operand_1, {FBITS{1'b0}}};
                rem_d   = '0;
                root_d  = '0;
                iter_d  = '0;
                state_d = ST_EXEC;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (op_q == FPU_MUL) begin
          acc_d  = acc_next;
          step_d = step_q + 2'd1;
          if (step_q == STEP_HH) begin
            result_d = mul_res;
            error_d  = mul_err;
            state_d  = ST_DONE;
          end
        end else begin
          rad_d  = rad_q << 2;
          rem_d  = take ? rem_diff[N:0] : rem_sh[N:0];
          root_d = {root_q[N-2:0], take};
          iter_d = iter_q + IW'(1);
          if (iter_q == IW'(N - 1)) begin
            result_d = {{(WIDTH-N){1'b0}}, root_q[N-2:0], take};
            error_d  = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      step_q   <= '0;
      acc_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      iter_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE);
  assign error  = error_q;

endmodule

// File: tb/tb_fixed_point_engine.sv
// tb/tb_fixed_point_engine.sv - scoreboard bench for fixed_point_engine with a behavioural arithmetic model
module tb_fixed_point_engine;
  import fpu_pkg::*;

  localparam int WIDTH    = 32;
  localparam int FBITS    = 10;
  localparam int SQRT_LAT = (WIDTH + FBITS) / 2 + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic [31:0] result;
  logic        ready;
  logic        busy;
  logic        error;

  fixed_point_engine #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operation (operation),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .result    (result),
    .ready     (ready),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic in plain 64-bit integers; returns {error, result}
  function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s, lo, hi, x, r, t;
    logic [31:0] res;
    logic        err;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    hi  = (longint'(1) << 31) - 1;
    lo  = -(longint'(1) << 31);
    err = 1'b0;
    res = '0;
    s   = 0;
    if (op == FPU_SQRT) begin
      if (a[31]) begin
        err = 1'b1;
      end else begin
        x = longint'({32'd0, a}) << FBITS;
        r = 0;
        for (int k = (WIDTH + FBITS) / 2 - 1; k >= 0; k--) begin
          t = r | (longint'(1) << k);
          if (t * t <= x) r = t;
        end
        res = r[31:0];
      end
    end else begin
      if (op == FPU_ADD)      s = sa + sb;
      else if (op == FPU_SUB) s = sa - sb;
      else                    s = (sa * sb) >>> FBITS;
      res = s[31:0];
`ifdef FPU_SATURATE_EN
      if (s > hi) begin
        res = 32'h7FFF_FFFF;
        err = 1'b1;
      end else if (s < lo) begin
        res = 32'h8000_0000;
        err = 1'b1;
      end
`endif
    end
    return {err, res};
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] a);
    if (op == FPU_MUL) return 5;
    if (op == FPU_SQRT) return a[31] ? 1 : SQRT_LAT;
    return 1;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait_busy", busy, 0);
    start     = 1'b1;
    operation = op;
    operand_1 = a;
    operand_2 = b;
    e.res = er;
    e.err = ee;
    e.due = cyc + latency(op, a);
    sb_q.push_back(e);
    last_acc = cyc;
    @(negedge clk);
    start     = 1'b0;
    operand_1 = $urandom;
    operand_2 = $urandom;
  endtask

  task automatic issue_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    m = model(op, a, b);
    issue(op, a, b, m[31:0], m[32]);
  endtask

  always @(negedge clk) begin
    if (reset && ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("error", error, mon_e.err);
        check("ready_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    repeat (2) @(negedge clk);
    check("reset_result", result, 0);
    check("reset_ready", ready, 0);
    check("reset_busy", busy, 0);
    check("reset_error", error, 0);
    reset = 1'b1;

    issue(FPU_ADD, 32'h0000_0600, 32'h0000_0800, 32'h0000_0E00, 1'b0);
    issue(FPU_SUB, 32'h0000_0400, 32'h0000_0C00, 32'hFFFF_F800, 1'b0);

    issue(FPU_MUL, 32'hFFFF_FA00, 32'h0000_0800, 32'hFFFF_F400, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      check("mul_busy", busy, (k <= 5));
      @(negedge clk);
    end

    issue(FPU_SQRT, 32'h0000_0800, 32'h0, 32'h0000_05A8, 1'b0);
    issue(FPU_SQRT, 32'hFFFF_F000, 32'h0, 32'h0000_0000, 1'b1);

`ifdef FPU_SATURATE_EN
    issue(FPU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
`else
    issue(FPU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
`endif

    issue_model(FPU_MUL, 32'h8000_0000, 32'h8000_0000);
    issue_model(FPU_MUL, 32'h8000_0000, 32'h0000_0400);
    issue_model(FPU_SQRT, 32'h7FFF_FFFF, 32'h0);
    issue_model(FPU_SQRT, 32'h0000_0000, 32'h0);
    issue_model(FPU_SUB, 32'h8000_0000, 32'h0000_0001);

    // start pulsed mid-SQRT must be dropped without an extra ready
    issue(FPU_SQRT, 32'h0000_1000, 32'h0, 32'h0000_0800, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("busy_during_sqrt", busy, 1);
    start     = 1'b1;
    operation = FPU_ADD;
    operand_1 = 32'h0000_0001;
    operand_2 = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (op == FPU_MUL && $urandom_range(0, 1) == 1) begin
        a = {{16{a[15]}}, a[15:0]};
        b = {{16{b[15]}}, b[15:0]};
      end
      if (op == FPU_SQRT && $urandom_range(0, 3) != 0) a[31] = 1'b0;
      issue_model(op, a, b);
    end

    // asynchronous reset in cycle 10 of a SQRT discards it
    issue_model(FPU_SQRT, 32'h0012_3400, 32'h0);
    while (cyc < last_acc + 10) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 0);
    check("abort_result", result, 0);
    check("abort_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    issue(FPU_MUL, 32'h0000_0C00, 32'h0000_0400, 32'h0000_0C00, 1'b0);

    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
